// File: rtl/riscv_defs.sv
// Shared RISC-V encoding definitions used by the encoder and the decoder.
// Contents:
//   fmt_e      - request format codes (R, I, S, B, U, J; 6 and 7 are illegal)
//   OPC_*      - major opcode constants for the base integer ISA
//   FUNCT3_SLL/SRL - funct3 codes that turn an OP-IMM into a shift
package riscv_defs;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_ECALL  = 7'b1110011;

  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SRL = 3'b101;

endpackage

// File: rtl/insn_fifo.sv
// Circular FIFO holding encoded 32-bit instructions.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   push_i, data_i    - write request and data (ignored when full)
//   pop_i             - remove head (ignored when empty)
//   data_o            - head entry, zero while empty
//   full_o, empty_o   - occupancy flags
module insn_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic [31:0] data_i,
  input  logic        pop_i,
  output logic [31:0] data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   count_q, count_d;
  logic          pushEff, popEff;

  // DEPTH is a power of two, so the count MSB alone marks count == DEPTH.
  assign full_o  = count_q[AW];
  assign empty_o = (count_q == '0);
  assign pushEff = push_i && !full_o;
  assign popEff  = pop_i && !empty_o;

  // Forcing zero while empty keeps stale entries from leaking after a reset.
  assign data_o = empty_o ? 32'd0 : mem_q[rdPtr_q];

  // Pointers wrap naturally because their width is exactly log2(DEPTH).
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushEff) wrPtr_d = wrPtr_q + 1'b1;
    if (popEff)  rdPtr_d = rdPtr_q + 1'b1;
    case ({pushEff, popEff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; empty_o masks its contents.
  always_ff @(posedge clk) begin
    if (pushEff) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/insn_encoder.sv
// Assembles RISC-V instruction words from field requests and queues them.
// Ports:
//   clk, reset                      - clock, asynchronous active-high reset
//   in_valid/in_ready               - request handshake
//   in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//                                   - request fields
//   out_valid/out_ready/out_insn    - encoded instruction stream (FIFO head)
//   err_sticky, err_count, err_clr  - encode-error status and its clear
// Erroneous requests are consumed but never queued.
module insn_encoder
  import riscv_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic        err_sticky,
  output logic [7:0]  err_count,
  input  logic        err_clr
);

  logic [31:0] encInsn;
  logic        encErr;
  logic        isShift;
  logic        accept;
  logic        errHit;
  logic        fifoFull, fifoEmpty;
  logic        errSticky_q, errSticky_d;
  logic [7:0]  errCount_q, errCount_d;

  assign isShift = (in_opcode == OPC_IMM) &&
                   ((in_funct3 == FUNCT3_SLL) || (in_funct3 == FUNCT3_SRL));

  // Each range check asks whether the upper immediate bits are a pure
  // sign extension of the field that actually fits in the instruction.
  always_comb begin
    encInsn = 32'd0;
    encErr  = 1'b0;
    case (fmt_e'(in_fmt))
      FMT_R: encInsn = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: begin
        if (isShift) begin
          encInsn = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          encErr  = |in_imm[31:5];
        end else begin
          encInsn = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          encErr  = !((&in_imm[31:11]) || !(|in_imm[31:11]));
        end
      end
      FMT_S: begin
        encInsn = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        encErr  = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      FMT_B: begin
        encInsn = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], in_opcode};
        encErr  = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      end
      FMT_U: begin
        encInsn = {in_imm[31:12], in_rd, in_opcode};
        encErr  = |in_imm[11:0];
      end
      FMT_J: begin
        encInsn = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        encErr  = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      end
      default: encErr = 1'b1;
    endcase
  end

  // Readiness depends only on occupancy, so a pop never opens a full FIFO
  // in the same cycle; reset also blocks acceptance.
  assign in_ready = !fifoFull && !reset;
  assign accept   = in_valid && in_ready;
  assign errHit   = accept && encErr;

  // A clear coinciding with a new error restarts the status at that error.
  always_comb begin
    errSticky_d = errSticky_q;
    errCount_d  = errCount_q;
    if (err_clr) begin
      errSticky_d = errHit;
      errCount_d  = errHit ? 8'd1 : 8'd0;
    end else if (errHit) begin
      errSticky_d = 1'b1;
      if (errCount_q != 8'hFF) errCount_d = errCount_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errSticky_q <= 1'b0;
      errCount_q  <= 8'd0;
    end else begin
      errSticky_q <= errSticky_d;
      errCount_q  <= errCount_d;
    end
  end

  assign err_sticky = errSticky_q;
  assign err_count  = errCount_q;

  insn_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept && !encErr),
    .data_i  (encInsn),
    .pop_i   (out_ready),
    .data_o  (out_insn),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign out_valid = !fifoEmpty;

endmodule

// File: tb/tb_insn_encoder.sv
// Directed self-checking bench for insn_encoder with hand-computed vectors.
module tb_insn_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic        err_sticky;
  logic [7:0]  err_count;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  insn_encoder #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_insn   (out_insn),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  // Present a request on the inputs; the caller decides when to clock it in.
  task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] opc,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm);
    in_fmt    = fmt;
    in_opcode = opc;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    in_valid  = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    applyStimulus(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    #12;
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset out_insn", out_insn, 32'd0);
    checkOutput("reset err_sticky", {31'd0, err_sticky}, 32'd0);
    checkOutput("reset err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    checkOutput("post-reset in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] I-format");
    applyStimulus(3'd1, 7'b0010011, 5'd3, 5'd3, 5'd0, 3'd0, 7'd0, 32'd1311);
    tick(); in_valid = 1'b0;
    checkOutput("I out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("I insn", out_insn, 32'h51f18193);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checkOutput("I popped", {31'd0, out_valid}, 32'd0);

    $display("[TB] shift then R");
    applyStimulus(3'd1, 7'b0010011, 5'd18, 5'd9, 5'd0, 3'd5, 7'h20, 32'd12);
    tick();
    applyStimulus(3'd0, 7'b0110011, 5'd18, 5'd4, 5'd9, 3'd1, 7'd0, 32'd0);
    tick(); in_valid = 1'b0;
    checkOutput("shift insn", out_insn, 32'h40c4d913);
    out_ready = 1'b1; tick();
    checkOutput("R insn", out_insn, 32'h00921933);
    tick(); out_ready = 1'b0;
    checkOutput("shift/R drained", {31'd0, out_valid}, 32'd0);

    $display("[TB] B, S, U, J formats");
    applyStimulus(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
    tick();
    applyStimulus(3'd2, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8);
    tick();
    applyStimulus(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    tick();
    applyStimulus(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    tick(); in_valid = 1'b0;
    checkOutput("B insn", out_insn, 32'hfe000ee3);
    out_ready = 1'b1; tick();
    checkOutput("S insn", out_insn, 32'h00512423);
    tick();
    checkOutput("U insn", out_insn, 32'h123452b7);
    tick();
    checkOutput("J insn", out_insn, 32'h008000ef);
    tick(); out_ready = 1'b0;
    checkOutput("formats drained", {31'd0, out_valid}, 32'd0);

    $display("[TB] errors");
    applyStimulus(3'd1, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick(); in_valid = 1'b0;
    checkOutput("err I no write", {31'd0, out_valid}, 32'd0);
    checkOutput("err I sticky", {31'd0, err_sticky}, 32'd1);
    checkOutput("err I count", {24'd0, err_count}, 32'd1);
    applyStimulus(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    tick(); in_valid = 1'b0;
    checkOutput("err B count", {24'd0, err_count}, 32'd2);
    checkOutput("err B no write", {31'd0, out_valid}, 32'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checkOutput("clr sticky", {31'd0, err_sticky}, 32'd0);
    checkOutput("clr count", {24'd0, err_count}, 32'd0);
    applyStimulus(3'd6, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    applyStimulus(3'd4, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000001);
    tick(); in_valid = 1'b0;
    checkOutput("err fmt6+U count", {24'd0, err_count}, 32'd2);
    applyStimulus(3'd1, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32);
    err_clr = 1'b1;
    tick(); in_valid = 1'b0; err_clr = 1'b0;
    checkOutput("clr+err sticky", {31'd0, err_sticky}, 32'd1);
    checkOutput("clr+err count", {24'd0, err_count}, 32'd1);
    checkOutput("clr+err no write", {31'd0, out_valid}, 32'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    $display("[TB] backpressure");
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(3'd1, 7'b0010011, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      tick();
      checkOutput("bp head held", out_insn, 32'h00000093);
    end
    applyStimulus(3'd1, 7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    checkOutput("bp full in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    checkOutput("bp 5th blocked", out_insn, 32'h00000093);
    out_ready = 1'b1;
    tick();
    checkOutput("bp pop while full", out_insn, 32'h00000113);
    checkOutput("bp in_ready reopened", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("bp push/pop 1", out_insn, 32'h00000193);
    applyStimulus(3'd1, 7'b0010011, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick(); in_valid = 1'b0;
    checkOutput("bp push/pop 2", out_insn, 32'h00000213);
    tick();
    checkOutput("bp order 5", out_insn, 32'h00000293);
    tick();
    checkOutput("bp order 6", out_insn, 32'h00000313);
    tick(); out_ready = 1'b0;
    checkOutput("bp drained", {31'd0, out_valid}, 32'd0);

    $display("[TB] reset mid-operation");
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(3'd1, 7'b0010011, 5'(i + 7), 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      tick();
    end
    checkOutput("pre-reset head", out_insn, 32'h00000413);
    reset = 1'b1;
    #1;
    checkOutput("mid-reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid-reset out_insn", out_insn, 32'd0);
    tick();
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    checkOutput("after reset in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("after reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("after reset out_insn", out_insn, 32'd0);
    applyStimulus(3'd0, 7'b0110011, 5'd18, 5'd4, 5'd9, 3'd1, 7'd0, 32'd0);
    tick(); in_valid = 1'b0;
    checkOutput("post-reset fresh head", out_insn, 32'h00921933);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
